sum_accumulator: RTL
====================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2: adder operand width; i_result is WIDTH+1 bits.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 8: accumulator width; legal range ACC_WIDTH >= WIDTH+1.
REQ-003 The block SHALL have parameter COUNT, default 4: samples per block; legal range 1..255.
REQ-004 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous and active-low.
REQ-006 i_valid  input  1  i_result carries a sample this cycle.
REQ-007 i_result  input  WIDTH+1  unsigned sum from the upstream ripple-carry adder.
REQ-008 i_clear  input  1  synchronous abort of the current block.
REQ-009 i_out_ready  input  1  consumer accepts o_sum.
REQ-010 o_ready  output  1  block accepts samples.
REQ-011 o_sum  output  ACC_WIDTH  registered accumulator value.
REQ-012 o_valid  output  1  o_sum holds a completed block total.
REQ-013 o_overflow  output  1  sticky saturation flag for the current block.
REQ-014 o_count  output  8  samples accepted in the current block.

Function
REQ-015 The block SHALL implement two states: ACCUM (o_ready=1, o_valid=0) and DONE (o_ready=0, o_valid=1).
REQ-016 A sample SHALL be accepted only in ACCUM with i_valid=1; accept adds zero-extended i_result to the accumulator and increments o_count.
REQ-017 A sum exceeding 2^ACC_WIDTH-1 SHALL saturate the accumulator to all-ones and set o_overflow, which stays set until block end, clear or reset.
REQ-018 On the accept that makes o_count equal COUNT, the block SHALL enter DONE; o_valid SHALL rise on the cycle after that accept, with o_sum equal to the final total (one-cycle latency).
REQ-019 In ACCUM, o_sum SHALL show the running total, registered.
REQ-020 In DONE, o_sum, o_overflow and o_count SHALL hold stable, and i_valid SHALL be ignored.
REQ-021 In DONE, a cycle with i_out_ready=1 SHALL complete the handshake.
REQ-022 On handshake completion, the next cycle SHALL be ACCUM with o_sum=0, o_count=0 and o_overflow=0.
REQ-023 i_out_ready SHALL have no effect in ACCUM.
REQ-024 i_clear=1 SHALL force ACCUM with o_sum, o_count and o_overflow all 0 on the next cycle, from either state.
REQ-025 When i_clear=1, any simultaneous sample or handshake SHALL be discarded.
REQ-026 Idle cycles (i_valid=0) SHALL not change state, count or sum.
REQ-027 For COUNT=1, every accept SHALL go straight to DONE.
REQ-028 Priority SHALL be: reset > i_clear > handshake/accept.

Reset
REQ-029 With i_rst_n=0 at a rising edge, the next cycle SHALL be ACCUM with o_sum=0, o_count=0, o_overflow=0, o_valid=0 and o_ready=1.
REQ-030 Reset SHALL apply identically mid-block and in DONE, discarding any pending total.
REQ-031 Asserting i_rst_n=0 without a clock edge SHALL change no output.

Verification
REQ-032 Basic block (defaults): accept i_result 1,3,4,6 on consecutive cycles -> o_valid=1 the next cycle with o_sum=14, o_overflow=0, o_count=4.
REQ-033 Gaps: samples 2,0,7,5 with 1-3 idle cycles between them -> o_sum=14 only after the 4th accept; no premature o_valid.
REQ-034 Saturation (ACC_WIDTH=4, COUNT=3): samples 6,6,6 -> o_sum=15, o_overflow=1; after handshake, o_sum=0 and o_overflow=0.
REQ-035 Backpressure: hold i_out_ready=0 for 5 cycles in DONE while driving i_valid=1, i_result=7 -> o_sum, o_valid and o_ready=0 stable; the first post-handshake block total excludes those samples.
REQ-036 Clear/reset mid-block: after 2 accepts (3,5), pulse i_clear together with i_valid -> o_sum=0, o_count=0; repeat using i_rst_n=0 instead -> same result with o_valid=0.

Source files
------------

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Brief    : Sums COUNT adder results per block with saturation, then holds
//            the total until the consumer handshakes it away.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
    parameter int WIDTH     = 2,
    parameter int ACC_WIDTH = 8,
    parameter int COUNT     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [WIDTH:0]       i_result,
    input  logic                 i_clear,
    input  logic                 i_out_ready,
    output logic                 o_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_valid,
    output logic                 o_overflow,
    output logic [7:0]           o_count
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [7:0] C_BLOCK_LEN = 8'(COUNT);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           count_q, count_d;
    logic                 ovf_q, ovf_d;

    // One spare bit above the accumulator captures the carry used for saturation.
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic [7:0]           w_count_inc;

    assign w_sum_ext   = (ACC_WIDTH + 1)'(acc_q) + (ACC_WIDTH + 1)'(i_result);
    assign w_count_inc = count_q + 8'd1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (i_clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (i_valid) begin
                        if (w_sum_ext[ACC_WIDTH]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = w_sum_ext[ACC_WIDTH-1:0];
                        end
                        count_d = w_count_inc;
                        if (w_count_inc == C_BLOCK_LEN) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready    = (state_q == ACCUM);
    assign o_valid    = (state_q == DONE);
    assign o_sum      = acc_q;
    assign o_overflow = ovf_q;
    assign o_count    = count_q;

endmodule
`default_nettype wire
